// File: rtl/vji_host_driver_if.sv
// Command/response handshake and virtual-JTAG pin bundle between a host
// driver (master) and the host/TAP-side environment (slave).
interface vji_host_driver_if #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic [DR_WIDTH-1:0] cmd_dr;
   logic                cmd_dr_en;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_data;
   logic                tck;
   logic                tdi;
   logic                tdo;
   logic [IR_WIDTH-1:0] ir_in;
   logic                vs_uir;
   logic                vs_cdr;
   logic                vs_sdr;
   logic                vs_udr;
   logic                jtag_state_rti;

   modport master (
      input  cmd_valid, cmd_ir, cmd_dr, cmd_dr_en, rsp_ready, tdo,
      output cmd_ready, rsp_valid, rsp_data, tck, tdi, ir_in,
             vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
   );

   modport slave (
      output cmd_valid, cmd_ir, cmd_dr, cmd_dr_en, rsp_ready, tdo,
      input  cmd_ready, rsp_valid, rsp_data, tck, tdi, ir_in,
             vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
   );
endinterface

// File: rtl/vji_host_driver.sv
// Host-side virtual JTAG driver: turns an IR/DR command into a UIR/CDR/SDR/UDR
// strobe sequence with a divided tck and returns the DR word captured on tdo.
module vji_host_driver #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int TCK_DIV  = 2
) (
   input  logic              clk,
   input  logic              reset,
   vji_host_driver_if.master bus
);
   localparam int CW = $clog2(DR_WIDTH + 1);
   localparam logic [7:0]    DIV_LAST = 8'(TCK_DIV - 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(DR_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [7:0]          div_q, div_d;
   logic                tck_q, tck_d;
   logic [CW-1:0]       bit_q, bit_d;
   logic [DR_WIDTH-1:0] tx_q, tx_d;
   logic [DR_WIDTH-1:0] rx_q, rx_d;
   logic [DR_WIDTH-1:0] rsp_q, rsp_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic                en_q, en_d;

   logic timed, half_end, rise, fall;

   // Scan states run on whole tck periods; a period ends on the tck fall.
   assign timed    = (state_q == S_UIR) || (state_q == S_CDR) ||
                     (state_q == S_SDR) || (state_q == S_UDR);
   assign half_end = timed && (div_q == DIV_LAST);
   assign rise     = half_end && !tck_q;
   assign fall     = half_end && tck_q;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tck_d   = tck_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rsp_d   = rsp_q;
      ir_d    = ir_q;
      en_d    = en_q;

      if (timed) begin
         if (half_end) begin
            div_d = 8'd0;
            tck_d = ~tck_q;
         end else begin
            div_d = div_q + 8'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               ir_d    = bus.cmd_ir;
               tx_d    = bus.cmd_dr;
               en_d    = bus.cmd_dr_en;
               rx_d    = '0;
               bit_d   = '0;
               div_d   = 8'd0;
               tck_d   = 1'b0;
               state_d = S_UIR;
            end
         end
         S_UIR: begin
            if (fall) begin
               if (en_q) begin
                  state_d = S_CDR;
               end else begin
                  rsp_d   = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_CDR: begin
            if (fall) state_d = S_SDR;
         end
         S_SDR: begin
            if (rise) rx_d = {bus.tdo, rx_q[DR_WIDTH-1:1]};
            if (fall) begin
               tx_d  = tx_q >> 1;
               bit_d = bit_q + CW'(1);
               if (bit_q == BIT_LAST) state_d = S_UDR;
            end
         end
         S_UDR: begin
            if (fall) begin
               rsp_d   = rx_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= 8'd0;
         tck_q   <= 1'b0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rsp_q   <= '0;
         ir_q    <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tck_q   <= tck_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rsp_q   <= rsp_d;
         ir_q    <= ir_d;
         en_q    <= en_d;
      end
   end

   // Strobes decode straight from state, so they move only at state entry (tck low).
   assign bus.cmd_ready      = (state_q == S_IDLE);
   assign bus.rsp_valid      = (state_q == S_DONE);
   assign bus.rsp_data       = rsp_q;
   assign bus.tck            = tck_q;
   assign bus.tdi            = (state_q == S_SDR) && tx_q[0];
   assign bus.ir_in          = ir_q;
   assign bus.vs_uir         = (state_q == S_UIR);
   assign bus.vs_cdr         = (state_q == S_CDR);
   assign bus.vs_sdr         = (state_q == S_SDR);
   assign bus.vs_udr         = (state_q == S_UDR);
   assign bus.jtag_state_rti = (state_q == S_IDLE) || (state_q == S_DONE);
endmodule

// File: tb/tb_vji_host_driver.sv
// Directed bench: three drivers (TCK_DIV 2, 1, 5) each looped to a shift-register
// slave model that counts tck rises per strobe and watches tdi/strobe legality.
module tb_vji_host_driver;
   localparam int DW = 38;
   localparam int IW = 2;
   localparam logic [10:0] RST_OV = 11'h00C;

   logic clk, reset;
   logic [IW-1:0] c_ir;
   logic [DW-1:0] c_dr;
   logic c_en;
   logic [2:0] cv, rr, ld, rv, crdy;
   logic [2:0][DW-1:0] pre, rd, srv;
   logic [2:0][10:0] ov;
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < 3; k++) begin : g
      localparam int TD = (k == 0) ? 2 : ((k == 1) ? 1 : 5);
      vji_host_driver_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) bus ();
      vji_host_driver #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(TD)) dut (
         .clk(clk), .reset(reset), .bus(bus)
      );
      logic [DW-1:0] sr;
      logic [IW-1:0] ir_seen;
      logic ptdi;
      int n_uir, n_cdr, n_sdr, n_udr, n_ord, n_tdi, n_hot;

      assign bus.cmd_valid = cv[k];
      assign bus.cmd_ir    = c_ir;
      assign bus.cmd_dr    = c_dr;
      assign bus.cmd_dr_en = c_en;
      assign bus.rsp_ready = rr[k];
      assign bus.tdo       = sr[0];
      assign rv[k]   = bus.rsp_valid;
      assign crdy[k] = bus.cmd_ready;
      assign rd[k]   = bus.rsp_data;
      assign srv[k]  = sr;
      assign ov[k]   = {bus.tck, bus.tdi, bus.vs_uir, bus.vs_cdr, bus.vs_sdr, bus.vs_udr,
                        bus.rsp_valid, bus.cmd_ready, bus.jtag_state_rti, bus.ir_in};

      // TAP-side slave: samples tdi on tck rise, tdo is the register LSB.
      always @(posedge bus.tck or posedge ld[k]) begin
         if (ld[k]) begin
            sr <= pre[k];
            n_uir <= 0; n_cdr <= 0; n_sdr <= 0; n_udr <= 0; n_ord <= 0;
         end else begin
            if (bus.vs_uir) begin n_uir <= n_uir + 1; ir_seen <= bus.ir_in; end
            if (bus.vs_cdr) begin
               n_cdr <= n_cdr + 1;
               if (n_uir != 1 || n_sdr != 0) n_ord <= n_ord + 1;
            end
            if (bus.vs_sdr) begin
               sr <= {bus.tdi, sr[DW-1:1]};
               n_sdr <= n_sdr + 1;
               if (n_cdr != 1 || n_udr != 0) n_ord <= n_ord + 1;
            end
            if (bus.vs_udr) begin
               n_udr <= n_udr + 1;
               if (n_sdr != DW) n_ord <= n_ord + 1;
            end
         end
      end

      always @(negedge clk) begin
         if (bus.tck && (bus.tdi !== ptdi)) n_tdi <= n_tdi + 1;
         ptdi <= bus.tdi;
         if ($countones({bus.vs_uir, bus.vs_cdr, bus.vs_sdr, bus.vs_udr}) > 1) n_hot <= n_hot + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int k, input logic [DW-1:0] v);
      @(negedge clk);
      pre[k] = v;
      ld[k] = 1'b1;
      #1 ld[k] = 1'b0;
   endtask

   task automatic issue(input int k, input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                        input logic en, output int t0);
      int n = 0;
      while (!crdy[k] && n < 1000) begin @(negedge clk); n++; end
      chk("issue_ready", 64'(crdy[k]), 64'd1);
      c_ir = ir; c_dr = dr; c_en = en; cv[k] = 1'b1;
      @(negedge clk);
      t0 = cyc;
      cv[k] = 1'b0;
   endtask

   task automatic wait_rsp(input int k, input int t0, output int lat);
      int n = 0;
      while (!rv[k] && n < 2000) begin @(negedge clk); n++; end
      lat = rv[k] ? (cyc - t0 + 1) : -1;
   endtask

   task automatic consume(input int k);
      rr[k] = 1'b1;
      @(negedge clk);
      rr[k] = 1'b0;
   endtask

   initial begin
      int t0, lat, n;
      logic ok_v, ok_d, ok_r, saw;
      reset = 1'b0; cv = '0; rr = '0; ld = '0; c_ir = '0; c_dr = '0; c_en = 1'b0; pre = '0;
      t0 = 0; lat = 0;

      // Reset between clock edges
      #2 reset = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_outputs", 64'(ov[k]), 64'(RST_OV));
         chk("rst_rsp_data", 64'(rd[k]), 64'd0);
      end
      @(negedge clk);
      reset = 1'b0;

      // Loopback full scan
      preload(0, 38'h2A_1234_5678);
      issue(0, 2'b01, 38'h15_DEAD_BEEF, 1'b1, t0);
      wait_rsp(0, t0, lat);
      chk("loop_latency", 64'(lat), 64'd165);
      chk("loop_rsp", 64'(rd[0]), 64'h2A_1234_5678);
      chk("loop_slave_sr", 64'(srv[0]), 64'h15_DEAD_BEEF);
      chk("loop_uir_rises", 64'(g[0].n_uir), 64'd1);
      chk("loop_cdr_rises", 64'(g[0].n_cdr), 64'd1);
      chk("loop_sdr_rises", 64'(g[0].n_sdr), 64'd38);
      chk("loop_udr_rises", 64'(g[0].n_udr), 64'd1);
      chk("loop_order", 64'(g[0].n_ord), 64'd0);
      chk("loop_ir_at_uir", 64'(g[0].ir_seen), 64'd1);
      chk("loop_done_busy", 64'(crdy[0]), 64'd0);
      consume(0);

      // IR-only update
      preload(0, 38'h11_1111_1111);
      issue(0, 2'b11, 38'h2B_0000_FFFF, 1'b0, t0);
      wait_rsp(0, t0, lat);
      chk("ir_latency", 64'(lat), 64'd5);
      chk("ir_rsp_zero", 64'(rd[0]), 64'd0);
      chk("ir_uir_rises", 64'(g[0].n_uir), 64'd1);
      chk("ir_no_dr", 64'(g[0].n_cdr + g[0].n_sdr + g[0].n_udr), 64'd0);
      chk("ir_at_uir", 64'(g[0].ir_seen), 64'd3);
      chk("ir_slave_untouched", 64'(srv[0]), 64'h11_1111_1111);
      consume(0);
      chk("ir_held_in_idle", 64'(ov[0][1:0]), 64'd3);

      // Back-pressure, then back-to-back acceptance
      preload(0, 38'h3F_FFFF_0000);
      issue(0, 2'b10, 38'h0A_5A5A_C3C3, 1'b1, t0);
      wait_rsp(0, t0, lat);
      chk("bp_first_rsp", 64'(rd[0]), 64'h3F_FFFF_0000);
      preload(0, 38'h2A_AAAA_5555);
      c_ir = 2'b01; c_dr = 38'h15_0F0F_F0F0; c_en = 1'b1; cv[0] = 1'b1;
      ok_v = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (rv[0] !== 1'b1) ok_v = 1'b0;
         if (rd[0] !== 38'h3F_FFFF_0000) ok_d = 1'b0;
         if (crdy[0] !== 1'b0) ok_r = 1'b0;
      end
      chk("bp_valid_held", 64'(ok_v), 64'd1);
      chk("bp_data_stable", 64'(ok_d), 64'd1);
      chk("bp_not_ready", 64'(ok_r), 64'd1);
      rr[0] = 1'b1;
      @(negedge clk);
      rr[0] = 1'b0;
      chk("b2b_ready_next", 64'(crdy[0]), 64'd1);
      chk("b2b_valid_drop", 64'(rv[0]), 64'd0);
      @(negedge clk);
      t0 = cyc;
      cv[0] = 1'b0;
      chk("b2b_accepted", 64'(crdy[0]), 64'd0);
      wait_rsp(0, t0, lat);
      chk("b2b_latency", 64'(lat), 64'd165);
      chk("b2b_rsp", 64'(rd[0]), 64'h2A_AAAA_5555);
      chk("b2b_slave_sr", 64'(srv[0]), 64'h15_0F0F_F0F0);
      consume(0);

      // Reset in the middle of the DR shift
      preload(0, 38'h3C_CCCC_3333);
      issue(0, 2'b01, 38'h03_5555_AAAA, 1'b1, t0);
      n = 0;
      while (g[0].n_sdr < 10 && n < 1000) begin @(negedge clk); n++; end
      chk("mid_sdr_reached", 64'(g[0].n_sdr), 64'd10);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_outputs", 64'(ov[0]), 64'(RST_OV));
      chk("mid_rst_rsp_data", 64'(rd[0]), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      saw = 1'b0;
      repeat (200) begin @(negedge clk); saw |= rv[0]; end
      chk("mid_rst_no_rsp", 64'(saw), 64'd0);
      preload(0, 38'h3C_CCCC_3333);
      issue(0, 2'b01, 38'h03_5555_AAAA, 1'b1, t0);
      wait_rsp(0, t0, lat);
      chk("post_rst_latency", 64'(lat), 64'd165);
      chk("post_rst_rsp", 64'(rd[0]), 64'h3C_CCCC_3333);
      chk("post_rst_slave_sr", 64'(srv[0]), 64'h03_5555_AAAA);
      consume(0);

      // TCK_DIV = 1
      preload(1, 38'h25_A5A5_1E1E);
      issue(1, 2'b10, 38'h1A_5A5A_E1E1, 1'b1, t0);
      wait_rsp(1, t0, lat);
      chk("div1_latency", 64'(lat), 64'd83);
      chk("div1_rsp", 64'(rd[1]), 64'h25_A5A5_1E1E);
      chk("div1_slave_sr", 64'(srv[1]), 64'h1A_5A5A_E1E1);
      chk("div1_sdr_rises", 64'(g[1].n_sdr), 64'd38);
      consume(1);

      // TCK_DIV = 5
      preload(2, 38'h01_8000_0003);
      issue(2, 2'b11, 38'h3E_7FFF_FFFC, 1'b1, t0);
      wait_rsp(2, t0, lat);
      chk("div5_latency", 64'(lat), 64'd411);
      chk("div5_rsp", 64'(rd[2]), 64'h01_8000_0003);
      chk("div5_slave_sr", 64'(srv[2]), 64'h3E_7FFF_FFFC);
      chk("div5_order", 64'(g[2].n_ord), 64'd0);
      consume(2);

      chk("div2_tdi_stable", 64'(g[0].n_tdi), 64'd0);
      chk("div1_tdi_stable", 64'(g[1].n_tdi), 64'd0);
      chk("div5_tdi_stable", 64'(g[2].n_tdi), 64'd0);
      chk("div2_onehot", 64'(g[0].n_hot), 64'd0);
      chk("div1_onehot", 64'(g[1].n_hot), 64'd0);
      chk("div5_onehot", 64'(g[2].n_hot), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
